// File: rtl/sb_rx_clk_det_pkg.sv
// Shared types and default constants for the sideband RX clock detector.
package sb_rx_clk_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } det_state_e;

  localparam int EXP_HALF_DEF = 4;
  localparam int TOL_DEF      = 1;
  localparam int LOCK_CNT_DEF = 16;
  localparam int MISS_MAX_DEF = 2;
  localparam int TIMEOUT_DEF  = 32;
  localparam int CNT_W_DEF    = 6;

  // Inclusive window check written without subtraction so it never goes negative.
  function automatic logic within_tol(input int meas, input int center, input int tol);
    return ((meas + tol) >= center) && (meas <= (center + tol));
  endfunction

endpackage

// File: rtl/sb_bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sb_bit_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so q takes the pre-edge value of meta (a true 2-stage chain).
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sb_rx_clk_detector.sv
// Measures half-periods of the forwarded sideband clock in PLL cycles and
// qualifies lock / loss for the sideband RX path.
module sb_rx_clk_detector
  import sb_rx_clk_det_pkg::*;
#(
  parameter int EXP_HALF = EXP_HALF_DEF,
  parameter int TOL      = TOL_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int MISS_MAX = MISS_MAX_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             i_pll_clk,
  input  logic             i_rst_n,
  input  logic             i_sb_rx_clk,
  input  logic             i_enable,
  output logic             o_clk_locked,
  output logic             o_clk_lost,
  output logic             o_period_err,
  output logic [CNT_W-1:0] o_half_period
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(MISS_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(MISS_MAX - 1);

  det_state_e        state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [GOOD_W-1:0] good_q, good_nxt;
  logic [BAD_W-1:0]  bad_q, bad_nxt;
  logic              first_q, first_nxt;
  logic              locked_nxt, lost_nxt, err_nxt;
  logic [CNT_W-1:0]  half_nxt;

  logic sync_q, prev_q, strobe;
  logic [CNT_W-1:0] meas;
  logic meas_sat, meas_good, timeout;

  sb_bit_synchronizer u_sync (
    .clk   (i_pll_clk),
    .rst_n (i_rst_n),
    .d     (i_sb_rx_clk),
    .q     (sync_q)
  );

  always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
    if (!i_rst_n) prev_q <= 1'b0;
    else          prev_q <= sync_q;
  end

  // Both edges of the received clock count, so a half-period is edge-to-edge.
  assign strobe    = sync_q ^ prev_q;
  assign meas_sat  = (cnt_q == CNT_MAX);
  assign meas      = meas_sat ? CNT_MAX : cnt_q + 1'b1;
  assign meas_good = !meas_sat && within_tol(32'(meas), EXP_HALF, TOL);
  assign timeout   = (cnt_q >= TO_LAST);

  always_comb begin
    // NOTE: every output of this block is given a default first; a path that left one unassigned would infer a latch.
    state_nxt  = state_q;
    cnt_nxt    = meas_sat ? cnt_q : cnt_q + 1'b1;
    good_nxt   = good_q;
    bad_nxt    = bad_q;
    first_nxt  = first_q;
    locked_nxt = o_clk_locked;
    lost_nxt   = o_clk_lost;
    err_nxt    = 1'b0;
    half_nxt   = o_half_period;

    if (!i_enable) begin
      // Enable drop overrides every other event; loss indication survives it.
      state_nxt  = ST_IDLE;
      cnt_nxt    = '0;
      good_nxt   = '0;
      bad_nxt    = '0;
      first_nxt  = 1'b0;
      locked_nxt = 1'b0;
    end else begin
      if (strobe) cnt_nxt = '0;

      case (state_q)
        ST_IDLE: begin
          state_nxt = ST_ACQUIRE;
          cnt_nxt   = '0;
          good_nxt  = '0;
          bad_nxt   = '0;
          first_nxt = 1'b1;
          lost_nxt  = 1'b0;
        end

        ST_ACQUIRE: begin
          if (strobe) begin
            if (first_q) begin
              first_nxt = 1'b0;
            end else begin
              half_nxt = meas;
              if (meas_good) begin
                if (good_q == LOCK_LAST) begin
                  state_nxt  = ST_LOCKED;
                  locked_nxt = 1'b1;
                  lost_nxt   = 1'b0;
                  good_nxt   = '0;
                  bad_nxt    = '0;
                end else begin
                  good_nxt = good_q + 1'b1;
                end
              end else begin
                good_nxt = '0;
                err_nxt  = 1'b1;
              end
            end
          end else if (timeout) begin
            state_nxt  = ST_LOST;
            lost_nxt   = 1'b1;
            locked_nxt = 1'b0;
            good_nxt   = '0;
          end
        end

        ST_LOCKED: begin
          if (strobe) begin
            half_nxt = meas;
            if (meas_good) begin
              bad_nxt = '0;
            end else begin
              err_nxt = 1'b1;
              if (bad_q == BAD_LAST) begin
                state_nxt  = ST_ACQUIRE;
                locked_nxt = 1'b0;
                good_nxt   = '0;
                bad_nxt    = '0;
                first_nxt  = 1'b0;
              end else begin
                bad_nxt = bad_q + 1'b1;
              end
            end
          end else if (timeout) begin
            state_nxt  = ST_LOST;
            lost_nxt   = 1'b1;
            locked_nxt = 1'b0;
            bad_nxt    = '0;
          end
        end

        ST_LOST: begin
          // The returning edge only opens a new measurement window.
          if (strobe) begin
            state_nxt = ST_ACQUIRE;
            first_nxt = 1'b0;
            good_nxt  = '0;
            bad_nxt   = '0;
          end
        end

        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      good_q        <= '0;
      bad_q         <= '0;
      first_q       <= 1'b0;
      o_clk_locked  <= 1'b0;
      o_clk_lost    <= 1'b0;
      o_period_err  <= 1'b0;
      o_half_period <= '0;
    end else begin
      state_q       <= state_nxt;
      cnt_q         <= cnt_nxt;
      good_q        <= good_nxt;
      bad_q         <= bad_nxt;
      first_q       <= first_nxt;
      o_clk_locked  <= locked_nxt;
      o_clk_lost    <= lost_nxt;
      o_period_err  <= err_nxt;
      o_half_period <= half_nxt;
    end
  end

endmodule

// File: doc/sb_rx_clk_detector.md
Name: sb_rx_clk_detector

Overview:
- Receive-side monitor for the forwarded sideband clock. On the TX end, the sideband clock is produced by dividing the PLL clock by 8 (a toggle every 4 PLL cycles).
- Runs on the local PLL clock and oversamples the incoming sideband clock. Measures each half-period in PLL cycles and qualifies it against the expected value.
- Declares lock after enough consecutive good half-periods, and declares loss when edges stop.
- Feeds the sideband RX deserializer enable and the link-training sideband status.

Parameters:
- EXP_HALF, 4, expected half-period in PLL cycles (divide-by-8 source).
- TOL, 1, allowed absolute deviation from EXP_HALF, inclusive.
- LOCK_CNT, 16, consecutive good half-periods required to declare lock.
- MISS_MAX, 2, consecutive bad half-periods in LOCKED that force re-acquisition.
- TIMEOUT, 32, PLL cycles without an edge before loss is declared.
- CNT_W, 6, width of the half-period and timeout counters; must hold TIMEOUT.

Ports:
- i_pll_clk  input  1  local PLL clock (800 MHz); the only clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_sb_rx_clk  input  1  received sideband clock; asynchronous to i_pll_clk.
- i_enable  input  1  detector enable from sideband control; level.
- o_clk_locked  output  1  received clock qualified.
- o_clk_lost  output  1  sticky loss indicator.
- o_period_err  output  1  one-cycle pulse per out-of-tolerance half-period.
- o_half_period  output  CNT_W  last measured half-period, saturating.

Behaviour:
- Reset: every output is 0. State is IDLE. Synchronizer flops, counters, good/bad counts are all 0.
- Input path: 2-flop synchronizer, then one edge-detect register. A toggle of i_sb_rx_clk appears as a 1-cycle edge strobe 3 cycles later. Rising and falling edges are both counted.
- Half-period counter:
  - Increments every cycle and saturates at 2^CNT_W-1.
  - On an edge strobe, its current value plus 1 is the measured half-period, and the counter reloads to 0.
  - Nominal divide-by-8 input therefore measures 4.
- Good interval: |meas - EXP_HALF| <= TOL. Bad interval: anything else, including a saturated measurement.
- o_half_period updates on every edge strobe except the first edge in ACQUIRE.
- State IDLE:
  - Counters are held at 0; o_clk_locked = 0.
  - i_enable = 1 -> ACQUIRE and clear o_clk_lost.
- State ACQUIRE:
  - The first edge after entry starts measurement only; that partial interval is not judged.
  - Each good interval: good_cnt++.
  - Each bad interval: good_cnt = 0 and pulse o_period_err.
  - good_cnt reaching LOCK_CNT -> LOCKED. o_clk_locked rises the cycle after the LOCK_CNT-th good strobe.
- State LOCKED:
  - Good interval: bad_cnt = 0.
  - Bad interval: pulse o_period_err, bad_cnt++.
  - bad_cnt reaching MISS_MAX -> ACQUIRE with o_clk_locked = 0 and good_cnt = 0.
- Timeout: in ACQUIRE or LOCKED, TIMEOUT cycles with no edge strobe -> LOST, o_clk_lost = 1, o_clk_locked = 0.
- State LOST:
  - o_clk_lost is held.
  - Next edge strobe -> ACQUIRE. That edge is treated as the first edge. o_clk_lost stays 1 until lock is regained, then clears on the LOCKED entry cycle.
- i_enable = 0 in any state: -> IDLE next cycle. o_clk_locked and o_period_err clear; o_clk_lost keeps its value.
- Simultaneous events:
  - Timeout and edge in the same cycle: the edge wins, so the timeout is not taken.
  - Enable drop and any other event: the enable drop wins.
- Asynchronous reset mid-lock: all outputs drop to 0 immediately. Acquisition restarts from IDLE after release.

Decomposition:
- Shared package sb_rx_clk_det_pkg holds:
  - the state enum (IDLE, ACQUIRE, LOCKED, LOST);
  - the default constants EXP_HALF_DEF, TOL_DEF, LOCK_CNT_DEF, TIMEOUT_DEF.
- One sub-module, sb_bit_synchronizer: a 2-flop synchronizer with asynchronous active-low reset to 0, reusable by other sideband RX blocks.
- FSM, counters and edge detect stay in the top module.

Test Plan:
- Nominal lock: drive i_sb_rx_clk toggling every 4 PLL cycles, i_enable = 1 -> o_half_period = 4, no o_period_err, o_clk_locked rises after the 17th edge strobe (1 start + 16 good).
- Out of tolerance: toggle every 6 cycles -> o_period_err pulses once per strobe after the first, o_clk_locked never asserts.
- Jitter within tolerance: alternate half-periods 3 and 5 -> lock after 17 strobes, no errors.
- Clock stop after lock: hold i_sb_rx_clk static -> 32 cycles after the last strobe, o_clk_lost = 1 and o_clk_locked = 0. Restart the clock -> o_clk_lost clears when lock is regained.
- Glitches in LOCKED:
  - one 8-cycle half-period -> single o_period_err, lock kept;
  - two consecutive bad intervals -> o_clk_locked falls, re-acquisition follows.
- Control: deassert i_enable while locked -> o_clk_locked = 0 next cycle. Assert i_rst_n = 0 mid-lock -> all outputs 0 immediately, re-lock after release.
